// File: rtl/pixel_writer.sv
// Pixel writer: queues plot requests in a small FIFO and streams them to the VGA adapter,
// or sweeps the whole 160x120 screen with one colour. Optional macro: PIXEL_WRITER_CLIP_EN.
module pixel_writer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_x,
   input  logic [6:0] in_y,
   input  logic [2:0] in_colour,
   input  logic       clear_req,
   input  logic [2:0] clear_colour,
   output logic       busy,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = 18;
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
   localparam logic [7:0] C_X_MAX = 8'd159;
   localparam logic [6:0] C_Y_MAX = 7'd119;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [DW-1:0]   r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [AW:0]     r_count;
   logic [AW:0]     w_count_next;
   logic [7:0]      r_clr_x;
   logic [6:0]      r_clr_y;
   logic [2:0]      r_clr_colour;
   logic [7:0]      r_vga_x;
   logic [6:0]      r_vga_y;
   logic [2:0]      r_vga_colour;
   logic            r_vga_plot;

   logic            w_full;
   logic            w_empty;
   logic            w_clear_start;
   logic            w_push;
   logic            w_pop;
   logic            w_clr_last;
   logic            w_head_ok;
   logic [DW-1:0]   w_head;
   logic [7:0]      w_head_x;
   logic [6:0]      w_head_y;
   logic [2:0]      w_head_colour;

   assign w_full        = (r_count == C_DEPTH);
   assign w_empty       = (r_count == '0);
   assign w_clear_start = clear_req && (r_state != S_CLEAR);
   assign in_ready      = !w_full && (r_state != S_CLEAR) && !clear_req;
   assign w_push        = in_valid && in_ready;
   // A pending clear throws the queue away, so the head is not popped in that cycle.
   assign w_pop         = !w_empty && (r_state != S_CLEAR) && !clear_req;
   assign w_clr_last    = (r_clr_x == C_X_MAX) && (r_clr_y == C_Y_MAX);

   assign w_head        = r_mem[r_rd_ptr];
   assign w_head_x      = w_head[17:10];
   assign w_head_y      = w_head[9:3];
   assign w_head_colour = w_head[2:0];

`ifdef PIXEL_WRITER_CLIP_EN
   assign w_head_ok = (w_head_x <= C_X_MAX) && (w_head_y <= C_Y_MAX);
`else
   assign w_head_ok = 1'b1;
`endif

   assign busy       = !w_empty || (r_state == S_CLEAR);
   assign vga_x      = r_vga_x;
   assign vga_y      = r_vga_y;
   assign vga_colour = r_vga_colour;
   assign vga_plot   = r_vga_plot;

   always_comb begin
      w_count_next = r_count;
      if (w_clear_start) begin
         w_count_next = '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_clear_start)
               w_state_next = S_CLEAR;
            else if (w_count_next != '0)
               w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_clear_start)
               w_state_next = S_CLEAR;
            else if (w_count_next == '0)
               w_state_next = S_IDLE;
         end
         S_CLEAR: begin
            if (w_clr_last)
               w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   // Storage carries no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {in_x, in_y, in_colour};
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_clear_start) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_next;
      end
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_clr_x      <= '0;
         r_clr_y      <= '0;
         r_clr_colour <= '0;
      end else if (w_clear_start) begin
         r_clr_x      <= '0;
         r_clr_y      <= '0;
         r_clr_colour <= clear_colour;
      end else if (r_state == S_CLEAR) begin
         if (r_clr_x == C_X_MAX) begin
            r_clr_x <= '0;
            r_clr_y <= w_clr_last ? 7'd0 : r_clr_y + 1'b1;
         end else begin
            r_clr_x <= r_clr_x + 1'b1;
         end
      end
   end

   // Coordinates only change when a pixel is actually plotted; otherwise they hold.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         r_vga_x      <= '0;
         r_vga_y      <= '0;
         r_vga_colour <= '0;
         r_vga_plot   <= 1'b0;
      end else begin
         r_vga_plot <= 1'b0;
         if (r_state == S_CLEAR) begin
            r_vga_x      <= r_clr_x;
            r_vga_y      <= r_clr_y;
            r_vga_colour <= r_clr_colour;
            r_vga_plot   <= 1'b1;
         end else if (w_pop && w_head_ok) begin
            r_vga_x      <= w_head_x;
            r_vga_y      <= w_head_y;
            r_vga_colour <= w_head_colour;
            r_vga_plot   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: table-driven plot requests, scoreboard of expected pixels,
// hand-written clear / reset sequences. Honours PIXEL_WRITER_CLIP_EN when defined.
module tb_pixel_writer;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   typedef struct {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
      bit         exp_plot;
      logic [7:0] exp_x;
      logic [6:0] exp_y;
      logic [2:0] exp_c;
   } vec_t;

`ifdef PIXEL_WRITER_CLIP_EN
   localparam bit CLIP_ON = 1'b1;
`else
   localparam bit CLIP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_x = '0;
   logic [6:0] in_y = '0;
   logic [2:0] in_colour = '0;
   logic       clear_req = 1'b0;
   logic [2:0] clear_colour = '0;
   logic       busy;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int   n_checks = 0;
   int   n_fail = 0;
   pix_t exp_q[$];
   vec_t vecs[6];

   pixel_writer #(.DEPTH(4)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_x         (in_x),
      .in_y         (in_y),
      .in_colour    (in_colour),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .busy         (busy),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
      pix_t p;
      p.x = x;
      p.y = y;
      p.c = c;
      exp_q.push_back(p);
   endtask

   task automatic push_sweep(input logic [2:0] c);
      for (int yy = 0; yy < 120; yy++)
         for (int xx = 0; xx < 160; xx++)
            push_exp(8'(xx), 7'(yy), c);
   endtask

   task automatic wait_drain(input string name, input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk(name, exp_q.size(), 0);
   endtask

   // Scoreboard: every plotted pixel must match the oldest expected one.
   always @(negedge clk) begin
      if (vga_plot === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL pix: unexpected plot (%0d,%0d,%0d), required none", vga_x, vga_y, vga_colour);
         end else begin
            pix_t e;
            e = exp_q.pop_front();
            if (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c) begin
               n_fail++;
               $display("FAIL pix: got (%0d,%0d,%0d), required (%0d,%0d,%0d)",
                        vga_x, vga_y, vga_colour, e.x, e.y, e.c);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'd3,   7'd4,   3'd1, 1'b1,     8'd3,   7'd4,   3'd1};
      vecs[1] = '{8'd159, 7'd119, 3'd7, 1'b1,     8'd159, 7'd119, 3'd7};
      vecs[2] = '{8'd0,   7'd0,   3'd2, 1'b1,     8'd0,   7'd0,   3'd2};
      vecs[3] = '{8'd80,  7'd60,  3'd3, 1'b1,     8'd80,  7'd60,  3'd3};
      vecs[4] = '{8'd200, 7'd5,   3'd2, !CLIP_ON, 8'd200, 7'd5,   3'd2};
      vecs[5] = '{8'd1,   7'd1,   3'd6, 1'b1,     8'd1,   7'd1,   3'd6};

      // Reset state
      #2 resetn = 1'b1;
      #1;
      chk("rst_plot", vga_plot, 0);
      chk("rst_x", vga_x, 0);
      chk("rst_y", vga_y, 0);
      chk("rst_c", vga_colour, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 1);
      tick();
      tick();
      resetn = 1'b0;
      tick();

      // Single request: two edges from accept to plot
      in_valid = 1'b1; in_x = 8'd10; in_y = 7'd20; in_colour = 3'd5;
      #1;
      chk("lat_ready", in_ready, 1);
      push_exp(8'd10, 7'd20, 3'd5);
      tick();
      in_valid = 1'b0;
      chk("lat_plot_n", vga_plot, 0);
      chk("lat_busy_n", busy, 1);
      tick();
      chk("lat_plot", vga_plot, 1);
      chk("lat_x", vga_x, 10);
      chk("lat_y", vga_y, 20);
      chk("lat_c", vga_colour, 5);
      tick();
      chk("lat_busy_done", busy, 0);
      chk("lat_plot_done", vga_plot, 0);
      chk("hold_x", vga_x, 10);
      chk("hold_c", vga_colour, 5);
      wait_drain("lat_drain", 4);

      // Back-to-back table, including an off-screen entry
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1; in_x = vecs[i].x; in_y = vecs[i].y; in_colour = vecs[i].c;
         #1;
         chk("b2b_ready", in_ready, 1);
         if (vecs[i].exp_plot)
            push_exp(vecs[i].exp_x, vecs[i].exp_y, vecs[i].exp_c);
         tick();
      end
      in_valid = 1'b0;
      wait_drain("b2b_drain", 20);
      tick();
      chk("b2b_busy", busy, 0);

      // Queued entry, then clear with a simultaneous request
      in_valid = 1'b1; in_x = 8'd50; in_y = 7'd50; in_colour = 3'd1;
      #1;
      chk("pre_clr_ready", in_ready, 1);
      tick();
      chk("pre_clr_busy", busy, 1);
      in_x = 8'd7; in_y = 7'd7; in_colour = 3'd7;
      clear_req = 1'b1; clear_colour = 3'd3;
      #1;
      chk("clr_ready", in_ready, 0);
      push_sweep(3'd3);
      tick();
      clear_req = 1'b0; in_valid = 1'b0;
      chk("clr_no_pop", vga_plot, 0);
      chk("clr_busy", busy, 1);
      for (int i = 0; i < 100; i++) tick();
      clear_req = 1'b1; clear_colour = 3'd5;
      #1;
      chk("clr_ignore_ready", in_ready, 0);
      tick();
      clear_req = 1'b0;
      wait_drain("clr_drain", 19300);
      chk("clr_end_plot", vga_plot, 0);
      chk("clr_end_busy", busy, 0);
      chk("clr_end_ready", in_ready, 1);
      chk("clr_last_x", vga_x, 159);
      chk("clr_last_y", vga_y, 119);
      chk("clr_last_c", vga_colour, 3);

      // Reset in the middle of a clear
      clear_req = 1'b1; clear_colour = 3'd6;
      push_sweep(3'd6);
      tick();
      clear_req = 1'b0;
      for (int i = 0; i < 5100; i++) begin
         if (exp_q.size() <= 19200 - 5000) break;
         tick();
      end
      chk("mid_clr_count", exp_q.size(), 19200 - 5000);
      chk("mid_clr_plot", vga_plot, 1);
      #2 resetn = 1'b1;
      #1;
      chk("arst_plot", vga_plot, 0);
      chk("arst_x", vga_x, 0);
      chk("arst_y", vga_y, 0);
      chk("arst_c", vga_colour, 0);
      chk("arst_busy", busy, 0);
      exp_q.delete();
      tick();
      tick();
      resetn = 1'b0;
      tick();
      chk("post_rst_plot", vga_plot, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_ready", in_ready, 1);
      tick();
      chk("post_rst_plot2", vga_plot, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
